// File: rtl/psdsqrt_pkg.sv
// psdsqrt_pkg: shared widths and state encoding for the sequential square-root unit.
//   NBITS_OUT : root width (also the iteration count)
//   NBITS_IN  : radicand width, 2*NBITS_OUT
//   CNT_W     : width of the bit-index counter
//   busy_e    : IDLE / RUN controller state
package psdsqrt_pkg;
    localparam int NBITS_OUT = 16;
    localparam int NBITS_IN  = 2 * NBITS_OUT;
    localparam int CNT_W     = $clog2(NBITS_OUT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } busy_e;
endpackage

// File: rtl/psdsqrt_if.sv
// psdsqrt_if: control/data bundle between the external sequencer and psdsqrt.
//   start : one-cycle pulse, load xin and begin
//   stop  : one-cycle pulse, copy internal root to sqrt
//   xin   : radicand, sampled on the start edge
//   sqrt  : registered result
// master = sequencer side, slave = psdsqrt side.
interface psdsqrt_if;
    import psdsqrt_pkg::*;

    logic                 start;
    logic                 stop;
    logic [NBITS_IN-1:0]  xin;
    logic [NBITS_OUT-1:0] sqrt;

    modport master (output start, stop, xin, input  sqrt);
    modport slave  (input  start, stop, xin, output sqrt);
endinterface

// File: rtl/psdsqrt_step.sv
// psdsqrt_step: one combinational iteration of the shift/subtract square root.
//   rem      : xin - root^2 so far
//   root     : partial root, bits above bidx resolved, bidx and below zero
//   bidx     : bit being resolved this iteration
//   rem_nxt  : updated remainder
//   root_nxt : updated root
// Setting bit b grows root^2 by (root << (b+1)) + 2^(2b); the bit is taken
// when the remainder can absorb that increment, which is exactly
// xin >= (root | 2^b)^2 without a multiplier.
module psdsqrt_step
    import psdsqrt_pkg::*;
(
    input  logic [NBITS_IN-1:0]  rem,
    input  logic [NBITS_OUT-1:0] root,
    input  logic [CNT_W-1:0]     bidx,
    output logic [NBITS_IN-1:0]  rem_nxt,
    output logic [NBITS_OUT-1:0] root_nxt
);
    // Two spare bits: root << 16 plus 2^30 can exceed 32 bits.
    localparam int TW = NBITS_IN + 2;

    logic [5:0]    sh_root;
    logic [5:0]    sh_sq;
    logic [TW-1:0] trial;
    logic          take;

    assign sh_root = {2'b00, bidx} + 6'd1;
    assign sh_sq   = {1'b0, bidx, 1'b0};
    assign trial   = ({{(TW-NBITS_OUT){1'b0}}, root} << sh_root) + (TW'(1) << sh_sq);
    assign take    = {2'b00, rem} >= trial;

    assign rem_nxt  = take ? rem - trial[NBITS_IN-1:0] : rem;
    assign root_nxt = take ? (root | (NBITS_OUT'(1) << bidx)) : root;
endmodule

// File: rtl/psdsqrt.sv
// psdsqrt: sequential floor(sqrt(xin)), one root bit per clock, MSB first.
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears all state
//   bus   : psdsqrt_if.slave (start, stop, xin in; sqrt out)
// Start loads xin and runs NBITS_OUT iterations on the following edges.
// Stop copies the current internal root (partial if still running) into sqrt.
// Start while running restarts; start+stop together copies the old root first.
// Build option PSDSQRT_ROUND_EN: round to nearest on the final iteration,
// saturating at all-ones. Default build truncates.
module psdsqrt
    import psdsqrt_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    psdsqrt_if.slave bus
);
    logic [NBITS_IN-1:0]  rem;
    logic [NBITS_OUT-1:0] root;
    logic [NBITS_OUT-1:0] sqrt_q;
    logic [CNT_W-1:0]     cnt;
    busy_e                state;

    logic [NBITS_IN-1:0]  rem_nxt;
    logic [NBITS_OUT-1:0] root_nxt;
    logic [NBITS_OUT-1:0] root_fin;

    psdsqrt_step u_step (
        .rem      (rem),
        .root     (root),
        .bidx     (cnt),
        .rem_nxt  (rem_nxt),
        .root_nxt (root_nxt)
    );

`ifdef PSDSQRT_ROUND_EN
    // rem_nxt is xin - root^2 after the last bit; above root means the
    // true root is past root+0.5. Ties are impossible for integer xin.
    logic rnd_up;
    assign rnd_up   = (rem_nxt > {{(NBITS_IN-NBITS_OUT){1'b0}}, root_nxt}) && (root_nxt != '1);
    assign root_fin = root_nxt + NBITS_OUT'(rnd_up);
`else
    assign root_fin = root_nxt;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            rem    <= '0;
            root   <= '0;
            sqrt_q <= '0;
            cnt    <= '0;
            state  <= IDLE;
        end else begin
            // Stop reads root before any start/iteration update on this edge.
            if (bus.stop)
                sqrt_q <= root;

            if (bus.start) begin
                rem   <= bus.xin;
                root  <= '0;
                cnt   <= CNT_W'(NBITS_OUT - 1);
                state <= RUN;
            end else if (state == RUN) begin
                rem <= rem_nxt;
                if (cnt == '0) begin
                    root  <= root_fin;
                    state <= IDLE;
                end else begin
                    root <= root_nxt;
                    cnt  <= cnt - 1'b1;
                end
            end
        end
    end

    assign bus.sqrt = sqrt_q;
endmodule

// File: tb/tb_psdsqrt.sv
// tb_psdsqrt: randomized self-checking bench for psdsqrt against a
// multiplication-based reference of the bit-by-bit root rule.
// Honours PSDSQRT_ROUND_EN in the reference when the build defines it.
module tb_psdsqrt;
    logic clock = 1'b0;
    logic reset;
    int   npass = 0;
    int   ntot  = 0;

    always #5 clock = ~clock;

    psdsqrt_if bus ();

    psdsqrt dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Root after nb bits resolved (MSB first), using the literal rule
    // "keep bit b if (r|2^b)^2 <= x".
    function automatic logic [15:0] ref_root(input logic [31:0] x, input int nb);
        longint unsigned r, t, xx;
        r  = 0;
        xx = longint'(x);
        for (int i = 0; i < nb && i < 16; i++) begin
            t = r | (64'd1 << (15 - i));
            if (t * t <= xx) r = t;
        end
`ifdef PSDSQRT_ROUND_EN
        if (nb >= 16 && (xx - r * r) > r && r != 64'd65535) r = r + 1;
`endif
        return r[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // All drivers assume the caller sits at a negedge.
    task automatic do_start(input logic [31:0] x);
        bus.start = 1'b1;
        bus.xin   = x;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
    endtask

    // Wait n edges while scrambling xin to show it is ignored after start.
    task automatic idle(input int n);
        repeat (n) begin
            bus.xin = $urandom;
            @(negedge clock);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] x, input int n);
        do_start(x);
        idle(n);
        do_stop();
        chk(tag, {16'd0, bus.sqrt}, {16'd0, ref_root(x, n)});
    endtask

    initial begin
        logic [31:0] x, k;
        int n;
        logic [15:0] held;

        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.xin   = '0;
        reset     = 1'b1;
        #23 reset = 1'b0;
        @(negedge clock);
        chk("reset", {16'd0, bus.sqrt}, 32'd0);
        do_stop();
        chk("stop_no_start", {16'd0, bus.sqrt}, 32'd0);

        run("x123456", 32'd123456, 16);
        chk("x123456_abs", {16'd0, bus.sqrt}, 32'd351);
        run("x0", 32'd0, 16);
        run("x1", 32'd1, 16);
        run("x65536", 32'd65536, 16);
        chk("x65536_abs", {16'd0, bus.sqrt}, 32'd256);
        run("xmax", 32'hFFFF_FFFF, 16);
        chk("xmax_abs", {16'd0, bus.sqrt}, 32'd65535);
        run("x_ffff_sq", 32'd4294836225, 16);
        run("x_ffff_sq_m1", 32'd4294836224, 16);
        run("x3", 32'd3, 16);
        run("x4", 32'd4, 16);
        run("x132", 32'd132, 16);
        run("x133", 32'd133, 16);

        // A new start must not disturb the held result.
        held = bus.sqrt;
        do_start(32'd77);
        idle(6);
        chk("sqrt_hold", {16'd0, bus.sqrt}, {16'd0, held});
        idle(10);

        // Restart mid-run.
        do_start(32'd100);
        idle(4);
        do_start(32'd144);
        idle(16);
        do_stop();
        chk("restart", {16'd0, bus.sqrt}, {16'd0, ref_root(32'd144, 16)});

        // Early stop returns the partial root.
        run("early", 32'd123456, 3);

        // Start and stop on the same edge.
        run("x400", 32'd400, 16);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        bus.xin   = 32'd9;
        @(negedge clock);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("simul_old", {16'd0, bus.sqrt}, {16'd0, ref_root(32'd400, 16)});
        idle(16);
        do_stop();
        chk("simul_new", {16'd0, bus.sqrt}, {16'd0, ref_root(32'd9, 16)});

        // Reset mid-computation clears everything.
        do_start(32'd123456);
        idle(5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("reset_mid_sqrt", {16'd0, bus.sqrt}, 32'd0);
        idle(16);
        do_stop();
        chk("reset_mid_root", {16'd0, bus.sqrt}, 32'd0);

        // Perfect squares and their predecessors near both ends.
        for (int i = 0; i < 40; i++) begin
            if (i < 20) k = i + 1;
            else if (i < 30) k = 65535 - (i - 20);
            else k = $urandom_range(65535, 2);
            x = k * k;
            run("sq", x, 16);
            run("sq_m1", x - 1, 16);
        end

        // Random operands with random stop timing (partial and complete).
        for (int i = 0; i < 120; i++) begin
            x = $urandom;
            if (i % 3 == 0) x = x >> $urandom_range(31, 0);
            n = (i % 2 == 0) ? 16 + $urandom_range(3, 0) : $urandom_range(16, 0);
            run("rand", x, n);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
